// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller for the UART receiver: start detect, oversample edge/bit counting,
// checker enables and the per-frame data_valid / frame_err / parity_err pulses.
module uart_rx_ctrl #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_in,
  input  logic                             par_en,
  input  logic                             strt_err,
  input  logic                             par_err,
  input  logic                             stp_err,
  output logic [$clog2(PRESCALE)-1:0]      edge_cnt,
  output logic [$clog2(DATA_WIDTH+3)-1:0]  bit_cnt,
  output logic                             dat_samp_en,
  output logic                             deser_en,
  output logic                             strt_chk_en,
  output logic                             par_chk_en,
  output logic                             stp_chk_en,
  output logic                             data_valid,
  output logic                             frame_err,
  output logic                             parity_err
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low sample on rx_in
  // START  | start bit: start checker enabled
  // DATA   | data bits, LSB first; deser_en strobes at each bit end
  // PARITY | parity bit (only when par_en was set at start detect)
  // STOP   | stop bit; verdict pulse is issued in the first IDLE cycle

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 3);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST_DATA = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state, state_nx;
  logic [EW-1:0]  edge_nx;
  logic [BW-1:0]  bit_nx;
  logic           par_cap, par_cap_nx;
  logic           par_sticky, sticky_nx;
  logic           valid_nx, ferr_nx, perr_nx;
  logic           bit_end;

  assign bit_end = (edge_cnt == EDGE_LAST);

  always_comb begin
    state_nx   = state;
    edge_nx    = bit_end ? '0 : edge_cnt + 1'b1;
    bit_nx     = bit_end ? bit_cnt + 1'b1 : bit_cnt;
    par_cap_nx = par_cap;
    sticky_nx  = par_sticky;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    perr_nx    = 1'b0;
    case (state)
      IDLE: begin
        edge_nx   = '0;
        bit_nx    = '0;
        sticky_nx = 1'b0;
        if (!rx_in) begin
          state_nx   = START;
          par_cap_nx = par_en;
        end
      end
      START: begin
        if (bit_end) begin
          if (strt_err) begin
            state_nx = IDLE;
            edge_nx  = '0;
            bit_nx   = '0;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end && bit_cnt == BIT_LAST_DATA)
          state_nx = par_cap ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) begin
          sticky_nx = par_sticky | par_err;
          state_nx  = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx  = IDLE;
          edge_nx   = '0;
          bit_nx    = '0;
          sticky_nx = 1'b0;
          if (stp_err)         ferr_nx  = 1'b1;
          else if (par_sticky) perr_nx  = 1'b1;
          else                 valid_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        edge_nx  = '0;
        bit_nx   = '0;
      end
    endcase
  end

  // Enables are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      par_cap     <= 1'b0;
      par_sticky  <= 1'b0;
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      strt_chk_en <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      state       <= state_nx;
      edge_cnt    <= edge_nx;
      bit_cnt     <= bit_nx;
      par_cap     <= par_cap_nx;
      par_sticky  <= sticky_nx;
      dat_samp_en <= (state_nx != IDLE);
      deser_en    <= (state_nx == DATA) && (edge_nx == EDGE_LAST);
      strt_chk_en <= (state_nx == START);
      par_chk_en  <= (state_nx == PARITY);
      stp_chk_en  <= (state_nx == STOP);
      data_valid  <= valid_nx;
      frame_err   <= ferr_nx;
      parity_err  <= perr_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (PRESCALE=8, DATA_WIDTH=8): clean, glitch, parity/stop error,
// no-parity back-to-back and mid-frame reset scenarios with hand-computed expectations.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst, rx_in, par_en, strt_err, par_err, stp_err;
  logic [2:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, frame_err, parity_err;
  int         n_cmp = 0;
  int         n_err = 0;

  uart_rx_ctrl #(.PRESCALE(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en),
    .strt_err(strt_err), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " edge_cnt"}, 32'(edge_cnt), 0);
    check({tag, " bit_cnt"}, 32'(bit_cnt), 0);
    check({tag, " outputs"},
          32'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, frame_err, parity_err}), 0);
  endtask

  // Runs one frame starting with the start-detect edge; kind: 0 valid, 1 parity_err, 2 frame_err.
  // Observation k=0 is the first START cycle, k=len the first IDLE cycle.
  task automatic run_frame(input string name, input logic [7:0] data, input logic par,
                           input logic perr, input logic serr, input logic noise, input int kind);
    int len, bi, n_deser, n_mis, n_valid, n_perr, n_ferr, n_strt, n_par, n_stp, n_samp;
    int max_bit, pulse_at;
    logic last;
    len = (10 + int'(par)) * 8;
    {n_deser, n_mis, n_valid, n_perr, n_ferr, n_strt, n_par, n_stp, n_samp, max_bit} = '0;
    pulse_at = -1;
    rx_in = 1'b0; par_en = par;
    strt_err = noise; par_err = noise; stp_err = noise;
    tick();
    par_en = ~par;
    for (int k = 0; k <= len; k++) begin
      if (deser_en) begin n_deser++; if (k % 8 != 7) n_mis++; end
      if (data_valid) begin n_valid++; pulse_at = k; end
      if (parity_err) begin n_perr++; pulse_at = k; end
      if (frame_err) begin n_ferr++; pulse_at = k; end
      if (strt_chk_en) n_strt++;
      if (par_chk_en) n_par++;
      if (stp_chk_en) n_stp++;
      if (dat_samp_en) n_samp++;
      if (int'(bit_cnt) > max_bit) max_bit = int'(bit_cnt);
      if (k == len) break;
      bi = k / 8;
      last = (k % 8 == 7);
      rx_in = (bi == 0) ? 1'b0 : (bi <= 8) ? data[bi-1] : (par && bi == 9) ? ^data : 1'b1;
      strt_err = (bi == 0 && last) ? 1'b0 : noise;
      par_err  = (par && bi == 9 && last) ? perr : noise;
      stp_err  = (bi == len / 8 - 1 && last) ? serr : noise;
      tick();
    end
    rx_in = 1'b1; strt_err = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    check({name, " deser_en pulses"}, n_deser, 8);
    check({name, " deser_en off bit end"}, n_mis, 0);
    check({name, " strt_chk_en cycles"}, n_strt, 8);
    check({name, " par_chk_en cycles"}, n_par, par ? 8 : 0);
    check({name, " stp_chk_en cycles"}, n_stp, 8);
    check({name, " dat_samp_en cycles"}, n_samp, len);
    check({name, " max bit_cnt"}, max_bit, par ? 10 : 9);
    check({name, " data_valid pulses"}, n_valid, (kind == 0) ? 1 : 0);
    check({name, " parity_err pulses"}, n_perr, (kind == 1) ? 1 : 0);
    check({name, " frame_err pulses"}, n_ferr, (kind == 2) ? 1 : 0);
    check({name, " pulse cycle"}, pulse_at, len);
    check({name, " idle edge_cnt"}, 32'(edge_cnt), 0);
    check({name, " idle bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0;
    strt_err = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    tick(); tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick(); tick();
    check_idle_outputs("idle line high");

    // Clean frame with parity
    run_frame("clean_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    tick(); tick();

    // Error inputs held high outside their own bit end must be ignored
    run_frame("noise_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    tick(); tick();

    // Start glitch: line low for 2 cycles, start checker flags it at edge 7
    rx_in = 1'b0;
    tick();
    check("glitch strt_chk_en", 32'(strt_chk_en), 1);
    check("glitch edge0", 32'(edge_cnt), 0);
    tick();
    rx_in = 1'b1;
    bad = 0;
    for (int k = 1; k < 7; k++) begin
      if (deser_en) bad++;
      tick();
    end
    check("glitch edge7", 32'(edge_cnt), 7);
    strt_err = 1'b1;
    tick();
    strt_err = 1'b0;
    check_idle_outputs("glitch abort");
    for (int k = 0; k < 20; k++) begin
      if (deser_en || data_valid || frame_err || parity_err || dat_samp_en) bad++;
      tick();
    end
    check("glitch quiet", bad, 0);

    // Parity error only
    run_frame("par_err", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    tick();
    // Stop error together with parity error: frame_err wins
    run_frame("stp_par_err", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 2);
    tick();
    // Stop error without parity
    run_frame("stp_err_np", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    tick();

    // No parity, two back-to-back frames (second starts in the first IDLE cycle)
    run_frame("b2b_1", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame("b2b_2", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick(); tick();

    // Reset during DATA bit 3
    rx_in = 1'b0; par_en = 1'b1;
    tick();
    rx_in = 1'b1;
    for (int k = 0; k < 26; k++) tick();
    check("pre-reset bit_cnt", 32'(bit_cnt), 3);
    check("pre-reset edge_cnt", 32'(edge_cnt), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid-frame reset");
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (deser_en || data_valid || frame_err || parity_err || dat_samp_en) bad++;
      tick();
    end
    check("post-reset quiet", bad, 0);

    // Recovery after reset
    run_frame("after_rst", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
